// File: rtl/cache_addr_pkg.sv
// Shared widths, state encoding and derived line size for the
// cache line burst address generator.
package cache_addr_pkg;

    localparam int ADDR_BIT   = 20;
    localparam int TAG_BIT    = 6;
    localparam int INDEX_BIT  = 10;
    localparam int OFFSET_BIT = 4;
    localparam int LINE_BEATS = 2**OFFSET_BIT;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

endpackage

// File: rtl/cache_beat_counter.sv
// Loadable word-offset register plus an independent beat counter
// that marks the final beat of a line.
module cache_beat_counter
    import cache_addr_pkg::*;
#(
    parameter int offset_bit = OFFSET_BIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [offset_bit-1:0] start,
    input  logic                  inc,
    output logic [offset_bit-1:0] offset,
    output logic                  last
);

    logic [offset_bit-1:0] offset_q;
    logic [offset_bit-1:0] beat_q;

    // offset wraps naturally; beat_q alone decides line completion
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            offset_q <= '0;
            beat_q   <= '0;
        end else if (load) begin
            offset_q <= start;
            beat_q   <= '0;
        end else if (inc) begin
            offset_q <= offset_q + 1'b1;
            beat_q   <= beat_q + 1'b1;
        end
    end

    assign offset = offset_q;
    assign last   = (beat_q == '1);

endmodule

// File: rtl/cache_line_addr_gen.sv
// Cache line refill/writeback burst address generator.
// Define CACHE_CRITICAL_WORD_FIRST_EN to start bursts at req_offset.
module cache_line_addr_gen
    import cache_addr_pkg::*;
#(
    parameter int address_bit = ADDR_BIT,
    parameter int tag_bit     = TAG_BIT,
    parameter int index_bit   = INDEX_BIT,
    parameter int offset_bit  = OFFSET_BIT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [tag_bit-1:0]     req_tag,
    input  logic [index_bit-1:0]   req_index,
    input  logic [offset_bit-1:0]  req_offset,
    output logic                   addr_valid,
    input  logic                   addr_ready,
    output logic [address_bit-1:0] addr,
    output logic                   addr_last,
    output logic                   busy
);

    if (address_bit != tag_bit + index_bit + offset_bit) begin : g_bad_width
        $error("address_bit must equal tag_bit + index_bit + offset_bit");
    end

    state_t state_q, state_d;

    logic [tag_bit-1:0]    tag_q;
    logic [index_bit-1:0]  index_q;
    logic [offset_bit-1:0] offset;
    logic [offset_bit-1:0] start;
    logic                  last;
    logic                  accept;
    logic                  fire;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    assign start = req_offset;
`else
    logic unused_req_offset;
    assign unused_req_offset = ^req_offset;
    assign start = '0;
`endif

    assign accept = (state_q == ST_IDLE) && req_valid;
    assign fire   = (state_q == ST_BURST) && addr_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (req_valid)         state_d = ST_BURST;
            ST_BURST: if (addr_ready && last) state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_q   <= '0;
            index_q <= '0;
        end else if (accept) begin
            tag_q   <= req_tag;
            index_q <= req_index;
        end
    end

    cache_beat_counter #(
        .offset_bit (offset_bit)
    ) u_beat (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .start  (start),
        .inc    (fire),
        .offset (offset),
        .last   (last)
    );

    // address is forced to zero outside a burst
    always_comb begin
        req_ready  = 1'b1;
        addr_valid = 1'b0;
        busy       = 1'b0;
        addr_last  = 1'b0;
        addr       = '0;
        if (state_q == ST_BURST) begin
            req_ready  = 1'b0;
            addr_valid = 1'b1;
            busy       = 1'b1;
            addr_last  = last;
            addr       = {tag_q, index_q, offset};
        end
    end

endmodule

// File: tb/tb_cache_line_addr_gen.sv
// Scoreboard bench for cache_line_addr_gen: expected beats are queued
// at request time and compared as the DUT hands each address over.
module tb_cache_line_addr_gen;

    localparam int AB = 20;
    localparam int TB = 6;
    localparam int IB = 10;
    localparam int OB = 4;
    localparam int NB = 2**OB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [TB-1:0] req_tag;
    logic [IB-1:0] req_index;
    logic [OB-1:0] req_offset;
    logic          addr_valid;
    logic          addr_ready;
    logic [AB-1:0] addr;
    logic          addr_last;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int beats  = 0;

    logic [AB:0] sb_q[$];

    cache_line_addr_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_tag    (req_tag),
        .req_index  (req_index),
        .req_offset (req_offset),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .addr       (addr),
        .addr_last  (addr_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [AB:0] e;
        if (rst_n && addr_valid && addr_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_empty", 32'(addr), 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                chk("addr", 32'(addr), 32'(e[AB-1:0]));
                chk("last", 32'(addr_last), 32'(e[AB]));
            end
            beats++;
        end
    end

    task automatic push_line(input logic [TB-1:0] t,
                             input logic [IB-1:0] ix,
                             input logic [OB-1:0] off);
        logic [OB-1:0] o;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
        o = off;
`else
        o = '0;
`endif
        for (int i = 0; i < NB; i++) begin
            sb_q.push_back({(i == NB - 1), t, ix, o});
            o = o + 1'b1;
        end
    endtask

    task automatic send_req(input logic [TB-1:0] t,
                            input logic [IB-1:0] ix,
                            input logic [OB-1:0] off);
        int n;
        req_tag    = t;
        req_index  = ix;
        req_offset = off;
        req_valid  = 1'b1;
        push_line(t, ix, off);
        n = 0;
        while (!req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("req_timeout", 32'd0, 32'd1);
        beats = 0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_tag   = '0;
        req_index = '0;
    endtask

    task automatic wait_beats(input int k);
        int n;
        n = 0;
        while (beats < k && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("beat_timeout", 32'(beats), 32'(k));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(sb_q.size() == 0 && req_ready) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_tag    = '0;
        req_index  = '0;
        req_offset = '0;
        addr_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_addr_valid", 32'(addr_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_last", 32'(addr_last), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // plain line from offset 0
        send_req(6'h2A, 10'h155, 4'h0);
        chk("first_busy", 32'(busy), 32'd1);
        chk("first_addr", 32'(addr), 32'hA9550);
        wait_idle();
        chk("idle_ready", 32'(req_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_last", 32'(addr_last), 32'd0);

        // start offset 0xC (honoured only in critical-word-first build)
        send_req(6'h2A, 10'h155, 4'hC);
        wait_idle();

        // backpressure at beat 5
        send_req(6'h2A, 10'h155, 4'h0);
        wait_beats(5);
        addr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_addr", 32'(addr), 32'hA9555);
            chk("stall_valid", 32'(addr_valid), 32'd1);
        end
        @(posedge clk); #1;
        addr_ready = 1'b1;
        wait_idle();

        // second request arrives mid-burst
        send_req(6'h2A, 10'h155, 4'h0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        req_valid = 1'b1;
        #1;
        chk("busy_req_ready", 32'(req_ready), 32'd0);
        send_req(6'h01, 10'h3FF, 4'h0);
        chk("second_addr", 32'(addr), 32'h07FF0);
        wait_idle();

        // reset at beat 7
        send_req(6'h2A, 10'h155, 4'h0);
        wait_beats(7);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_valid", 32'(addr_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_addr", 32'(addr), 32'd0);
        sb_q.delete();
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_req(6'h2A, 10'h155, 4'h3);
        wait_idle();

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
